// File: rtl/rob_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rob_pkg                                                          |
// | Shared kind encodings, entry states and reset values for the ROB |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package rob_pkg;

    localparam logic [1:0] c_KIND_ALU    = 2'd0;
    localparam logic [1:0] c_KIND_BRANCH = 2'd1;
    localparam logic [1:0] c_KIND_JUMP   = 2'd2;
    localparam logic [1:0] c_KIND_LS     = 2'd3;

    typedef enum logic [2:0] {
        ST_EMPTY     = 3'd0,
        ST_EXEC      = 3'd1,
        ST_LS_RDY    = 3'd2,
        ST_LS_ISSUED = 3'd3,
        ST_DONE      = 3'd4
    } rob_state_e;

    localparam logic       c_RST_PULSE = 1'b0;
    localparam logic [4:0] c_RST_RD    = 5'd0;

endpackage
`default_nettype wire

// File: rtl/rob_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rob_wb_arbiter                                                   |
// | Maps writeback ports onto entries; lowest port index wins a tag  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module rob_wb_arbiter #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 3,
    parameter int XLEN   = 32,
    parameter int NUM_WB = 2
) (
    input  logic [NUM_WB-1:0]       wb_valid,
    input  logic [NUM_WB*TAG_W-1:0] wb_tag,
    input  logic [NUM_WB*XLEN-1:0]  wb_value,
    input  logic [NUM_WB-1:0]       wb_taken,
    output logic [DEPTH-1:0]        hit,
    output logic [DEPTH*XLEN-1:0]   hit_value,
    output logic [DEPTH-1:0]        hit_taken
);

    // Ports are scanned high to low so the lowest index is written last and wins.
    always_comb begin
        hit       = '0;
        hit_value = '0;
        hit_taken = '0;
        for (int e = 0; e < DEPTH; e++) begin
            for (int p = NUM_WB - 1; p >= 0; p--) begin
                if (wb_valid[p] && (wb_tag[p*TAG_W +: TAG_W] == TAG_W'(e))) begin
                    hit[e]                     = 1'b1;
                    hit_value[e*XLEN +: XLEN]  = wb_value[p*XLEN +: XLEN];
                    hit_taken[e]               = wb_taken[p];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rob_core_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rob_core_param                                                   |
// | Parametrised in-order-commit reorder buffer with flush/LS commit |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module rob_core_param
    import rob_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 3,
    parameter int XLEN   = 32,
    parameter int NUM_WB = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    input  logic [1:0]              alloc_kind,
    input  logic [4:0]              alloc_rd,
    input  logic [XLEN-1:0]         alloc_pc,
    input  logic [XLEN-1:0]         alloc_value,
    input  logic                    alloc_done,
    output logic [TAG_W-1:0]        alloc_tag,
    input  logic [NUM_WB-1:0]       wb_valid,
    input  logic [NUM_WB*TAG_W-1:0] wb_tag,
    input  logic [NUM_WB*XLEN-1:0]  wb_value,
    input  logic [NUM_WB-1:0]       wb_taken,
    input  logic                    ls_ready_valid,
    input  logic [TAG_W-1:0]        ls_ready_tag,
    input  logic [2*TAG_W-1:0]      q_tag,
    output logic [1:0]              q_ready,
    output logic [2*XLEN-1:0]       q_value,
    output logic                    commit_valid,
    output logic [4:0]              commit_rd,
    output logic [XLEN-1:0]         commit_value,
    output logic [TAG_W-1:0]        commit_tag,
    output logic                    ls_commit_valid,
    output logic [TAG_W-1:0]        ls_commit_tag,
    output logic                    redirect_valid,
    output logic [XLEN-1:0]         redirect_pc,
    output logic [TAG_W:0]          count
);

    localparam logic [TAG_W:0]   c_DEPTH   = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W-1:0] c_TAG_ONE = TAG_W'(1);
    localparam logic [TAG_W:0]   c_CNT_ONE = (TAG_W+1)'(1);
    localparam logic [XLEN-1:0]  c_PC_STEP = XLEN'(4);

    rob_state_e       r_state [DEPTH];
    logic [1:0]       r_kind  [DEPTH];
    logic [4:0]       r_rd    [DEPTH];
    logic [XLEN-1:0]  r_pc    [DEPTH];
    logic [XLEN-1:0]  r_value [DEPTH];
    logic             r_taken [DEPTH];
    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [TAG_W:0]   r_count;

    logic [DEPTH-1:0]      w_wb_hit;
    logic [DEPTH*XLEN-1:0] w_wb_value;
    logic [DEPTH-1:0]      w_wb_taken;
    logic                  w_alloc_fire;
    logic                  w_ls_issue;
    logic                  w_commit;
    logic                  w_redirect;
    logic [1:0]            w_head_kind;
    logic [4:0]            w_commit_rd;
    logic [XLEN-1:0]       w_commit_value;
    logic [TAG_W:0]        w_count_next;

    rob_wb_arbiter #(
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .XLEN   (XLEN),
        .NUM_WB (NUM_WB)
    ) u_wb_arbiter (
        .wb_valid  (wb_valid),
        .wb_tag    (wb_tag),
        .wb_value  (wb_value),
        .wb_taken  (wb_taken),
        .hit       (w_wb_hit),
        .hit_value (w_wb_value),
        .hit_taken (w_wb_taken)
    );

    assign alloc_ready  = (r_count < c_DEPTH) && !redirect_valid;
    assign alloc_tag    = r_tail;
    assign count        = r_count;
    assign w_alloc_fire = alloc_valid && alloc_ready;

    assign w_head_kind    = r_kind[r_head];
    assign w_ls_issue     = (r_state[r_head] == ST_LS_RDY);
    assign w_commit       = (r_state[r_head] == ST_DONE);
    assign w_redirect     = w_commit && ((w_head_kind == c_KIND_JUMP) ||
                            ((w_head_kind == c_KIND_BRANCH) && r_taken[r_head]));
    assign w_commit_rd    = (w_head_kind == c_KIND_BRANCH) ? 5'd0 : r_rd[r_head];
    // A jump's link value is its return address; its stored value is the target.
    assign w_commit_value = (w_head_kind == c_KIND_JUMP) ? (r_pc[r_head] + c_PC_STEP)
                                                         : r_value[r_head];

    always_comb begin
        w_count_next = r_count;
        if (w_alloc_fire && !w_commit) begin
            w_count_next = r_count + c_CNT_ONE;
        end else if (!w_alloc_fire && w_commit) begin
            w_count_next = r_count - c_CNT_ONE;
        end
    end

    generate
        for (genvar k = 0; k < 2; k++) begin : g_query
            logic [TAG_W-1:0] w_qtag;
            assign w_qtag                   = q_tag[k*TAG_W +: TAG_W];
            assign q_ready[k]               = (r_state[w_qtag] == ST_DONE);
            assign q_value[k*XLEN +: XLEN]  = r_value[w_qtag];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= ST_EMPTY;
                r_kind[i]  <= c_KIND_ALU;
                r_rd[i]    <= '0;
                r_pc[i]    <= '0;
                r_value[i] <= '0;
                r_taken[i] <= 1'b0;
            end
            commit_valid    <= c_RST_PULSE;
            commit_rd       <= c_RST_RD;
            commit_value    <= '0;
            commit_tag      <= '0;
            ls_commit_valid <= c_RST_PULSE;
            ls_commit_tag   <= '0;
            redirect_valid  <= c_RST_PULSE;
            redirect_pc     <= '0;
        end else begin
            commit_valid    <= 1'b0;
            ls_commit_valid <= 1'b0;
            redirect_valid  <= 1'b0;
            if (w_ls_issue) begin
                ls_commit_valid <= 1'b1;
                ls_commit_tag   <= r_head;
            end
            if (w_commit) begin
                commit_valid <= 1'b1;
                commit_rd    <= w_commit_rd;
                commit_value <= w_commit_value;
                commit_tag   <= r_head;
            end
            if (w_redirect) begin
                // Full flush: same-edge allocation and writebacks are dropped.
                redirect_valid <= 1'b1;
                redirect_pc    <= r_value[r_head];
                r_head         <= '0;
                r_tail         <= '0;
                r_count        <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    r_state[i] <= ST_EMPTY;
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_wb_hit[i] && ((r_state[i] == ST_EXEC) || (r_state[i] == ST_LS_ISSUED))) begin
                        r_state[i] <= ST_DONE;
                        r_value[i] <= w_wb_value[i*XLEN +: XLEN];
                        r_taken[i] <= w_wb_taken[i];
                    end else if (ls_ready_valid && (ls_ready_tag == TAG_W'(i)) &&
                                 (r_state[i] == ST_EXEC) && (r_kind[i] == c_KIND_LS)) begin
                        r_state[i] <= ST_LS_RDY;
                    end
                end
                if (w_ls_issue) begin
                    r_state[r_head] <= ST_LS_ISSUED;
                end
                if (w_commit) begin
                    r_state[r_head] <= ST_EMPTY;
                    r_head          <= r_head + c_TAG_ONE;
                end
                if (w_alloc_fire) begin
                    r_state[r_tail] <= alloc_done ? ST_DONE : ST_EXEC;
                    r_kind[r_tail]  <= alloc_kind;
                    r_rd[r_tail]    <= alloc_rd;
                    r_pc[r_tail]    <= alloc_pc;
                    r_value[r_tail] <= alloc_value;
                    r_taken[r_tail] <= 1'b0;
                    r_tail          <= r_tail + c_TAG_ONE;
                end
                r_count <= w_count_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rob_core_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rob_core_param                                                |
// | Scoreboard bench: queue-based ROB model vs rob_core_param        |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_rob_core_param;

    localparam int DEPTH  = 8;
    localparam int TAG_W  = 3;
    localparam int XLEN   = 32;
    localparam int NUM_WB = 2;

    localparam int S_EXEC = 1, S_LSRDY = 2, S_LSISS = 3, S_DONE = 4;
    localparam int K_ALU = 0, K_BR = 1, K_JMP = 2, K_LS = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    alloc_valid, alloc_ready, alloc_done;
    logic [1:0]              alloc_kind;
    logic [4:0]              alloc_rd;
    logic [XLEN-1:0]         alloc_pc, alloc_value;
    logic [TAG_W-1:0]        alloc_tag;
    logic [NUM_WB-1:0]       wb_valid, wb_taken;
    logic [NUM_WB*TAG_W-1:0] wb_tag;
    logic [NUM_WB*XLEN-1:0]  wb_value;
    logic                    ls_ready_valid;
    logic [TAG_W-1:0]        ls_ready_tag;
    logic [2*TAG_W-1:0]      q_tag;
    logic [1:0]              q_ready;
    logic [2*XLEN-1:0]       q_value;
    logic                    commit_valid, ls_commit_valid, redirect_valid;
    logic [4:0]              commit_rd;
    logic [XLEN-1:0]         commit_value, redirect_pc;
    logic [TAG_W-1:0]        commit_tag, ls_commit_tag;
    logic [TAG_W:0]          count;

    rob_core_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .NUM_WB(NUM_WB)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_kind(alloc_kind),
        .alloc_rd(alloc_rd), .alloc_pc(alloc_pc), .alloc_value(alloc_value),
        .alloc_done(alloc_done), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_taken(wb_taken),
        .ls_ready_valid(ls_ready_valid), .ls_ready_tag(ls_ready_tag),
        .q_tag(q_tag), .q_ready(q_ready), .q_value(q_value),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_tag(commit_tag), .ls_commit_valid(ls_commit_valid), .ls_commit_tag(ls_commit_tag),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .count(count)
    );

    always #5 clk = ~clk;

    // In-flight instructions, oldest first.
    typedef struct { int tag; int kind; logic [4:0] rd; logic [31:0] pc; logic [31:0] value; bit taken; int st; } ent_t;
    typedef struct { int stamp; logic [4:0] rd; logic [31:0] value; int tag; } cexp_t;
    typedef struct { int stamp; int tag; } lexp_t;
    typedef struct { int stamp; logic [31:0] pc; } rexp_t;

    ent_t  rob[$];
    cexp_t cq[$];
    lexp_t lq[$];
    rexp_t rq[$];
    int    next_tag = 0;
    bit    m_redir = 0;
    int    edge_idx = 0;
    int    total = 0;
    int    bad = 0;
    int    ls_pulses = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alloc_valid = 0; alloc_kind = 0; alloc_rd = 0; alloc_pc = 0; alloc_value = 0; alloc_done = 0;
        wb_valid = 0; wb_tag = 0; wb_value = 0; wb_taken = 0;
        ls_ready_valid = 0; ls_ready_tag = 0;
    endtask

    task automatic wb(input int port, input int tag, input logic [31:0] v, input bit tk);
        wb_valid[port]           = 1'b1;
        wb_tag[port*TAG_W +: TAG_W] = TAG_W'(tag);
        wb_value[port*XLEN +: XLEN] = v;
        wb_taken[port]           = tk;
    endtask

    // Applies one clock edge of the behavioural model to the currently driven inputs.
    task automatic model_apply();
        bit flush, can_alloc;
        int hact;
        logic [DEPTH-1:0] seen;
        ent_t e;
        flush = 0; hact = 0; seen = '0;
        if (rst) begin
            rob.delete(); next_tag = 0; m_redir = 0;
            return;
        end
        can_alloc = (rob.size() < DEPTH) && !m_redir;
        if (rob.size() > 0) begin
            if (rob[0].st == S_LSRDY) hact = 1;
            else if (rob[0].st == S_DONE) hact = 2;
        end
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p]) begin
                int t;
                t = int'(wb_tag[p*TAG_W +: TAG_W]);
                if (!seen[t]) begin
                    seen[t] = 1'b1;
                    foreach (rob[i])
                        if (rob[i].tag == t && (rob[i].st == S_EXEC || rob[i].st == S_LSISS)) begin
                            rob[i].value = wb_value[p*XLEN +: XLEN];
                            rob[i].taken = wb_taken[p];
                            rob[i].st    = S_DONE;
                        end
                end
            end
        end
        if (ls_ready_valid)
            foreach (rob[i])
                if (rob[i].tag == int'(ls_ready_tag) && rob[i].st == S_EXEC && rob[i].kind == K_LS)
                    rob[i].st = S_LSRDY;
        if (hact == 1) begin
            rob[0].st = S_LSISS;
            lq.push_back('{edge_idx, rob[0].tag});
        end else if (hact == 2) begin
            e = rob.pop_front();
            cq.push_back('{edge_idx, (e.kind == K_BR) ? 5'd0 : e.rd,
                           (e.kind == K_JMP) ? e.pc + 32'd4 : e.value, e.tag});
            if (e.kind == K_JMP || (e.kind == K_BR && e.taken)) begin
                rq.push_back('{edge_idx, e.value});
                flush = 1;
            end
        end
        if (alloc_valid && can_alloc && !flush) begin
            e.tag = next_tag; e.kind = int'(alloc_kind); e.rd = alloc_rd; e.pc = alloc_pc;
            e.value = alloc_value; e.taken = 0; e.st = alloc_done ? S_DONE : S_EXEC;
            rob.push_back(e);
            next_tag = (next_tag + 1) % DEPTH;
        end
        if (flush) begin
            rob.delete(); next_tag = 0;
        end
        m_redir = flush;
    endtask

    function automatic int pick_tag();
        if (rob.size() > 0 && ($urandom % 4) != 0) return rob[$urandom_range(0, rob.size() - 1)].tag;
        return int'($urandom % DEPTH);
    endfunction

    task automatic check_state();
        check("count", count, rob.size());
        check("alloc_ready", alloc_ready, (rob.size() < DEPTH) && !m_redir);
        check("alloc_tag", alloc_tag, next_tag);
        q_tag = {TAG_W'(pick_tag()), TAG_W'(pick_tag())};
        #1;
        for (int k = 0; k < 2; k++) begin
            int t; bit er; logic [31:0] ev;
            t = int'(q_tag[k*TAG_W +: TAG_W]); er = 0; ev = 0;
            foreach (rob[i]) if (rob[i].tag == t && rob[i].st == S_DONE) begin er = 1; ev = rob[i].value; end
            check("q_ready", q_ready[k], er);
            if (er) check("q_value", q_value[k*XLEN +: XLEN], ev);
        end
    endtask

    task automatic step();
        model_apply();
        @(posedge clk);
        edge_idx++;
        @(negedge clk);
        check_state();
    endtask

    task automatic alloc_one(input int kind, input int rd, input logic [31:0] pc, input logic [31:0] v, input bit done);
        idle_inputs();
        alloc_valid = 1; alloc_kind = 2'(kind); alloc_rd = 5'(rd); alloc_pc = pc; alloc_value = v; alloc_done = done;
        step();
    endtask

    task automatic do_reset();
        idle_inputs(); rst = 1; step(); rst = 0;
    endtask

    // Monitor: pops expectations whenever the DUT presents a pulse.
    always @(negedge clk) begin
        if (commit_valid) begin
            if (cq.size() != 0 && cq[0].stamp == edge_idx - 1) begin
                cexp_t c;
                c = cq.pop_front();
                check("commit_tag", commit_tag, c.tag);
                check("commit_rd", commit_rd, c.rd);
                check("commit_value", commit_value, c.value);
            end else begin
                total++; bad++;
                $display("FAIL commit_unexpected: got tag=%0d required no commit", commit_tag);
            end
        end else if (cq.size() != 0 && cq[0].stamp < edge_idx) begin
            total++; bad++;
            $display("FAIL commit_missing: got no commit required tag=%0d", cq[0].tag);
            void'(cq.pop_front());
        end
        if (ls_commit_valid) begin
            ls_pulses++;
            if (lq.size() != 0 && lq[0].stamp == edge_idx - 1) begin
                lexp_t l;
                l = lq.pop_front();
                check("ls_commit_tag", ls_commit_tag, l.tag);
            end else begin
                total++; bad++;
                $display("FAIL ls_unexpected: got tag=%0d required no pulse", ls_commit_tag);
            end
        end else if (lq.size() != 0 && lq[0].stamp < edge_idx) begin
            total++; bad++;
            $display("FAIL ls_missing: got no pulse required tag=%0d", lq[0].tag);
            void'(lq.pop_front());
        end
        if (redirect_valid) begin
            if (rq.size() != 0 && rq[0].stamp == edge_idx - 1) begin
                rexp_t r;
                r = rq.pop_front();
                check("redirect_pc", redirect_pc, r.pc);
            end else begin
                total++; bad++;
                $display("FAIL redirect_unexpected: got pc=0x%0h required no redirect", redirect_pc);
            end
        end else if (rq.size() != 0 && rq[0].stamp < edge_idx) begin
            total++; bad++;
            $display("FAIL redirect_missing: got no redirect required pc=0x%0h", rq[0].pc);
            void'(rq.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs(); rst = 1; q_tag = '0;
        @(negedge clk);
        step(); step();
        rst = 0;
        check("rst_commit_valid", commit_valid, 0);
        check("rst_redirect_valid", redirect_valid, 0);
        check("rst_ls_valid", ls_commit_valid, 0);

        // Full ROB, head completes; the allocation on the freeing edge is refused.
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc_one(K_ALU, i + 1, 32'h100 + 32'(4 * i), 0, 0);
        check("t1_count_full", count, 8);
        check("t1_ready_full", alloc_ready, 0);
        idle_inputs(); wb(0, 0, 32'h55, 0); alloc_valid = 1; step();
        idle_inputs(); alloc_valid = 1; step();
        check("t1_commit_valid", commit_valid, 1);
        check("t1_commit_tag", commit_tag, 0);
        check("t1_commit_value", commit_value, 32'h55);
        check("t1_count_after", count, 7);

        // Out-of-order writebacks commit in order.
        do_reset();
        for (int i = 0; i < 3; i++) alloc_one(K_ALU, 10 + i, 32'h40, 0, 0);
        idle_inputs(); wb(0, 2, 32'h2, 0); step();
        idle_inputs(); wb(1, 1, 32'h1, 0); step();
        idle_inputs(); wb(0, 0, 32'h0, 0); step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_order_tag", commit_tag, i);
            check("t2_order_valid", commit_valid, 1);
        end

        // Load/store handshake then writeback.
        do_reset();
        alloc_one(K_LS, 5, 32'h200, 0, 0);
        idle_inputs(); ls_ready_valid = 1; ls_ready_tag = 0; ls_pulses = 0; step();
        idle_inputs(); step();
        check("t3_ls_valid", ls_commit_valid, 1);
        check("t3_ls_tag", ls_commit_tag, 0);
        step(); step(); step();
        check("t3_ls_once", ls_pulses, 1);
        wb(0, 0, 32'hAB, 0); step();
        idle_inputs(); step();
        check("t3_commit_value", commit_value, 32'hAB);

        // Taken branch at head flushes younger entries.
        do_reset();
        alloc_one(K_BR, 0, 32'h300, 0, 0);
        for (int i = 0; i < 3; i++) alloc_one(K_ALU, 1 + i, 32'h304, 0, 0);
        idle_inputs(); wb(0, 0, 32'h1000, 1); step();
        idle_inputs(); alloc_valid = 1; step();
        check("t4_redirect_valid", redirect_valid, 1);
        check("t4_redirect_pc", redirect_pc, 32'h1000);
        check("t4_count", count, 0);
        check("t4_ready_low", alloc_ready, 0);
        step();
        check("t4_count_after", count, 0);
        idle_inputs(); step();
        check("t4_ready_back", alloc_ready, 1);

        // Dual-port writeback to one tag: port 0 wins.
        do_reset();
        for (int i = 0; i < 4; i++) alloc_one(K_ALU, 1 + i, 32'h400, 0, 0);
        idle_inputs(); wb(0, 3, 32'h11, 0); wb(1, 3, 32'h22, 0); step();
        idle_inputs();
        q_tag = {TAG_W'(0), TAG_W'(3)};
        #1;
        check("t5_q_ready", q_ready[0], 1);
        check("t5_q_value", q_value[XLEN-1:0], 32'h11);

        // Reset while full with a load/store issued.
        do_reset();
        alloc_one(K_LS, 7, 32'h500, 0, 0);
        for (int i = 1; i < DEPTH; i++) alloc_one(K_ALU, i, 32'h504, 0, 0);
        idle_inputs(); ls_ready_valid = 1; ls_ready_tag = 0; step();
        idle_inputs(); step();
        rst = 1; alloc_valid = 1; wb(0, 0, 32'h77, 0); ls_ready_valid = 1; step();
        rst = 0; idle_inputs();
        check("t6_count", count, 0);
        check("t6_alloc_tag", alloc_tag, 0);
        check("t6_outputs", {commit_valid, ls_commit_valid, redirect_valid, commit_rd, commit_tag, ls_commit_tag}, 0);
        check("t6_data", {commit_value, redirect_pc}, 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            int r;
            idle_inputs();
            rst = (($urandom % 200) == 0);
            if (($urandom % 10) < 6) begin
                r = int'($urandom % 10);
                alloc_valid = 1;
                alloc_kind  = (r < 6) ? 2'd0 : (r == 6) ? 2'd1 : (r == 7) ? 2'd2 : 2'd3;
                alloc_rd    = 5'($urandom);
                alloc_pc    = $urandom & 32'hFFFF_FFFC;
                alloc_value = $urandom;
                alloc_done  = (($urandom % 7) == 0);
            end
            for (int p = 0; p < NUM_WB; p++)
                if ($urandom % 2) wb(p, pick_tag(), $urandom, ($urandom % 3) == 0);
            if (($urandom % 3) == 0) begin
                ls_ready_valid = 1;
                ls_ready_tag   = TAG_W'(pick_tag());
            end
            step();
            rst = 0;
        end
        idle_inputs(); step(); step();
        #2;
        check("sb_drained", cq.size() + lq.size() + rq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rob_core_param.md
Name: rob_core_param

Overview:
- Parametrised in-order-commit reorder buffer: successor of the fixed 7-entry ROB.
- Configurable depth, data width and number of writeback (CDB) ports.
- Adds per-entry PC storage, operand-forwarding query ports, a one-shot load/store commit handshake and full flush on redirect.
- Sits between decode/issue (allocation), the ALU/LSU writeback buses and the register file / PC unit (commit).

Parameters:
- DEPTH, 8, number of entries; power of two, at least 4.
- TAG_W, 3, tag width; equals log2(DEPTH).
- XLEN, 32, data and PC width.
- NUM_WB, 2, number of writeback ports.

Ports:
- clk in 1: clock.
- rst in 1: synchronous active-high reset.
- alloc_valid in 1: allocation request.
- alloc_ready out 1: combinational; equals (count < DEPTH) and not redirect_valid.
- alloc_kind in 2: entry kind, ALU/BRANCH/JUMP/LS.
- alloc_rd in 5: destination register; 0 means none.
- alloc_pc in XLEN: instruction PC.
- alloc_value in XLEN: initial value (immediate or LUI result).
- alloc_done in 1: entry is complete at allocation (LUI/AUIPC).
- alloc_tag out TAG_W: combinational; equals tail.
- wb_valid in NUM_WB: writeback valid, one bit per port.
- wb_tag in NUM_WB*TAG_W: writeback tags.
- wb_value in NUM_WB*XLEN: result value, or target PC for BRANCH/JUMP.
- wb_taken in NUM_WB: branch taken flag.
- ls_ready_valid in 1: the LS entry at ls_ready_tag has its address/data resolved.
- ls_ready_tag in TAG_W: tag for ls_ready_valid.
- q_tag in 2*TAG_W: two forwarding queries.
- q_ready out 2: combinational; entry is valid and DONE.
- q_value out 2*XLEN: combinational; entry value.
- commit_valid out 1: registered one-cycle pulse.
- commit_rd out 5: committed destination register.
- commit_value out XLEN: committed value.
- commit_tag out TAG_W: committed tag.
- ls_commit_valid out 1: registered one-cycle pulse.
- ls_commit_tag out TAG_W: tag for ls_commit_valid.
- redirect_valid out 1: registered one-cycle pulse.
- redirect_pc out XLEN: redirect target PC.
- count out TAG_W+1: current occupancy.

Behaviour:
- Entry state per slot: EMPTY, EXEC, LS_RDY, LS_ISSUED, DONE. Entry fields: kind, rd, pc, value, taken.
- Reset, synchronous: head=0, tail=0, count=0, all entries EMPTY, every registered output 0. Reset overrides all same-cycle events, including mid-flush and mid-LS.
- Allocation: fires when alloc_valid && alloc_ready at a posedge.
  - Writes the entry; state becomes DONE if alloc_done, else EXEC.
  - Tail increments modulo DEPTH (natural wrap); no reserved tag 0.
- Writeback, port p with wb_valid[p]:
  - Target entry in EXEC or LS_ISSUED: value := wb_value, taken := wb_taken, state := DONE.
  - Writeback to an EMPTY or DONE entry is ignored.
  - Two ports naming the same tag in one cycle: lowest port index wins.
- ls_ready_valid moves an EXEC entry of kind LS to LS_RDY; it is ignored in any other state.
- Head decision each cycle (combinational on head; outputs registered next edge):
  - LS_RDY: ls_commit_valid=1, ls_commit_tag=head, state := LS_ISSUED. Exactly one pulse per entry.
  - DONE with kind ALU or LS: commit_valid=1 with rd/value/tag; slot freed; head++.
  - DONE with kind JUMP: commit_value = pc+4; redirect_valid=1, redirect_pc = value.
  - DONE with kind BRANCH: commit_valid=1 with commit_rd=0; redirect only if taken, redirect_pc = value.
  - Otherwise: no pulse.
- Redirect flush, same edge that registers redirect_valid:
  - head=tail=count=0, all entries EMPTY.
  - Same-edge allocation and writebacks are discarded.
  - alloc_ready stays 0 while redirect_valid is high.
- count: +1 on allocate, -1 on commit, both on the same edge gives net 0. A full ROB does not accept an allocation on the edge that frees a slot.
- At most one commit per cycle.
- Queries on EMPTY or non-DONE entries return q_ready=0 and q_value=entry value (don't-care).

Decomposition:
- Package rob_pkg: kind encodings (ALU=0, BRANCH=1, JUMP=2, LS=3), the state enum, and the RESET values of the outputs.
- One natural sub-module, rob_wb_arbiter: resolves the per-entry writeback hit and lowest-index priority across the NUM_WB ports.

Test Plan:
1. Allocate 8 ALU entries with no writeback -> count=8, alloc_ready=0. Writeback tag 0 value 0x55 -> next cycle commit_valid, commit_tag=0, commit_value=0x55. The allocation on that edge is refused.
2. Writebacks arrive out of order, tags 2,1,0 -> commits emitted strictly in order 0,1,2 on consecutive cycles.
3. LS entry at head gets ls_ready -> exactly one ls_commit_valid pulse with tag=head. A later wb_value 0xAB then commits with value 0xAB.
4. BRANCH at head written back with taken=1, target 0x1000, and 3 younger entries present -> redirect_valid with redirect_pc=0x1000. count=0 next cycle; a same-cycle alloc is dropped.
5. Both wb ports target tag 3 with values 0x11 (port 0) and 0x22 (port 1) -> q_value for tag 3 reads 0x11 and q_ready=1.
6. Assert rst while the ROB is full and LS_ISSUED is pending -> all outputs 0, count=0, alloc_tag=0 the next cycle.
